// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART receive controller
package uart_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int TO_BITS_DEF    = 16;

    localparam logic [1:0] ST_OFF_ENC   = 2'd0;
    localparam logic [1:0] ST_IDLE_ENC  = 2'd1;
    localparam logic [1:0] ST_RECV_ENC  = 2'd2;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd3;

    typedef enum logic [1:0] {
        S_OFF   = ST_OFF_ENC,
        S_IDLE  = ST_IDLE_ENC,
        S_RECV  = ST_RECV_ENC,
        S_DRAIN = ST_DRAIN_ENC
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous show-ahead receive FIFO
//
// Ports:
//   clk, reset_n      clock; asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    push request and word
//   rd_en             pop request (ignored while empty)
//   rd_data           head word, valid whenever empty=0 (reads as 0 when empty)
//   full, empty       occupancy flags
//   count             number of stored words
//   wr_drop           push request that could not be stored this cycle
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = FIFO_DEPTH_DEF
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);
    assign wr_drop = wr_en && !do_wr;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)
                count <= count + CW'(1);
            else if (do_rd && !do_wr)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: config shadowing, receive FIFO, status
//
// Ports:
//   clk, reset_n                      clock; asynchronous active-high reset
//   cfg_en, cfg_ratio, cfg_parity_en,
//   cfg_parity_odd, cfg_flow,
//   cfg_timeout                       configuration (ratio/parity captured on enable)
//   rx_busy, rx_new_data,
//   rx_parity_err, rx_data            status and data from the bit receiver
//   rx_enb, ratio, parity_en,
//   parity_odd                        start permission and shadowed settings to the receiver
//   rd_en, rd_data, rd_perr, rd_valid show-ahead read port
//   fifo_count                        FIFO occupancy
//   overflow, timeout_irq, perr_count sticky status, cleared by stat_clr
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int RATIO_REG_SIZE = 8,
    parameter int DATA_BITS      = 8,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int TO_BITS        = TO_BITS_DEF
)(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_en,
    input  logic [RATIO_REG_SIZE-1:0]     cfg_ratio,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_flow,
    input  logic [TO_BITS-1:0]            cfg_timeout,
    input  logic                          rx_busy,
    input  logic                          rx_new_data,
    input  logic                          rx_parity_err,
    input  logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_enb,
    output logic [RATIO_REG_SIZE-1:0]     ratio,
    output logic                          parity_en,
    output logic                          parity_odd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          timeout_irq,
    output logic [7:0]                    perr_count,
    input  logic                          stat_clr
);

    rx_state_t          state;
    rx_state_t          state_d;
    logic               shadow_load;
    logic               fifo_full;
    logic               fifo_empty;
    logic               wr_en;
    logic               wr_drop;
    logic               wr_ok;
    logic               rd_fire;
    logic [DATA_BITS:0] fifo_rd_word;
    logic [TO_BITS-1:0] to_cnt;
    logic [TO_BITS-1:0] to_next;
    logic               to_hit;
    logic               to_run;
    logic               to_set;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) state <= S_OFF;
        else         state <= state_d;
    end

    always_comb begin
        state_d     = state;
        shadow_load = 1'b0;
        rx_enb      = 1'b0;
        case (state)
            S_OFF: begin
                if (cfg_en) begin
                    shadow_load = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                // Flow control only holds off new frames; a started frame is never cut.
                rx_enb = !(cfg_flow && fifo_full);
                if (rx_busy)      state_d = S_RECV;
                else if (!cfg_en) state_d = S_OFF;
            end
            S_RECV: begin
                rx_enb = 1'b1;
                // Frame end (data or framing abort) returns to IDLE, which then
                // honours a disable; otherwise a disable lets the frame finish in DRAIN.
                if (rx_new_data || !rx_busy) state_d = S_IDLE;
                else if (!cfg_en)            state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!rx_busy && !rx_new_data) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Receiver settings only move on the OFF->IDLE edge so a live frame never
    // sees its ratio or parity change underneath it.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ratio      <= '0;
            parity_en  <= 1'b0;
            parity_odd <= 1'b0;
        end else if (shadow_load) begin
            ratio      <= cfg_ratio;
            parity_en  <= cfg_parity_en;
            parity_odd <= cfg_parity_odd;
        end
    end

    assign wr_en = rx_new_data && (state != S_OFF);

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data ({rx_parity_err, rx_data}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .wr_drop (wr_drop)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_rd_word[DATA_BITS-1:0];
    assign rd_perr  = fifo_rd_word[DATA_BITS];
    assign wr_ok    = wr_en && !wr_drop;
    assign rd_fire  = rd_en && !fifo_empty;

    // Idle timeout: counts clocks while data sits unread and the line is quiet.
    // The irq is raised on the same edge the count reaches the limit, then the count holds.
    assign to_next = to_cnt + TO_BITS'(1);
    assign to_hit  = (cfg_timeout != '0) && (to_cnt >= cfg_timeout);
    assign to_run  = !rx_busy && rd_valid && (cfg_timeout != '0) && !to_hit;
    assign to_set  = to_run && (to_next == cfg_timeout);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            to_cnt      <= '0;
            timeout_irq <= 1'b0;
            overflow    <= 1'b0;
            perr_count  <= 8'd0;
        end else begin
            if (stat_clr || wr_en || rd_fire)
                to_cnt <= '0;
            else if (to_run)
                to_cnt <= to_next;

            if (stat_clr)
                timeout_irq <= 1'b0;
            else if (to_set && !wr_en && !rd_fire)
                timeout_irq <= 1'b1;

            if (stat_clr)
                overflow <= 1'b0;
            else if (wr_drop)
                overflow <= 1'b1;

            if (stat_clr)
                perr_count <= 8'd0;
            else if (wr_ok && rx_parity_err && (perr_count != 8'hFF))
                perr_count <= perr_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a queue-based reference model
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int M_OFF = 0, M_IDLE = 1, M_RECV = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cfg_en = 1'b0;
    logic [7:0]  cfg_ratio = 8'd0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_flow = 1'b0;
    logic [15:0] cfg_timeout = 16'd0;
    logic        rx_busy = 1'b0;
    logic        rx_new_data = 1'b0;
    logic        rx_parity_err = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rd_en = 1'b0;
    logic        stat_clr = 1'b0;
    logic        rx_enb;
    logic [7:0]  ratio;
    logic        parity_en;
    logic        parity_odd;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_valid;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        timeout_irq;
    logic [7:0]  perr_count;

    uart_rx_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_en         (cfg_en),
        .cfg_ratio      (cfg_ratio),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_flow       (cfg_flow),
        .cfg_timeout    (cfg_timeout),
        .rx_busy        (rx_busy),
        .rx_new_data    (rx_new_data),
        .rx_parity_err  (rx_parity_err),
        .rx_data        (rx_data),
        .rx_enb         (rx_enb),
        .ratio          (ratio),
        .parity_en      (parity_en),
        .parity_odd     (parity_odd),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_perr        (rd_perr),
        .rd_valid       (rd_valid),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .timeout_irq    (timeout_irq),
        .perr_count     (perr_count),
        .stat_clr       (stat_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [8:0] q[$];
    int         m_st;
    int         m_to;
    int         m_perr;
    logic       m_irq, m_ovf, m_pen, m_podd;
    logic [7:0] m_ratio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = M_OFF; m_to = 0; m_perr = 0;
        m_irq = 0; m_ovf = 0; m_pen = 0; m_podd = 0; m_ratio = 0;
    endtask

    task automatic model_step();
        int  pre;
        bit  wr, rd, acc;
        if (reset_n) begin
            model_reset();
            return;
        end
        pre = q.size();
        wr  = rx_new_data && (m_st != M_OFF);
        rd  = rd_en && (pre > 0);
        acc = wr && ((pre < DEPTH) || rd);
        if (rd)  void'(q.pop_front());
        if (acc) q.push_back({rx_parity_err, rx_data});

        if (stat_clr || wr || rd) m_to = 0;
        else if (!rx_busy && pre > 0 && cfg_timeout != 0 && m_to < int'(cfg_timeout)) begin
            m_to++;
            if (m_to == int'(cfg_timeout)) m_irq = 1;
        end
        if (stat_clr) begin
            m_irq = 0; m_ovf = 0; m_perr = 0;
        end else begin
            if (wr && !acc) m_ovf = 1;
            if (acc && rx_parity_err && m_perr < 255) m_perr++;
        end

        case (m_st)
            M_OFF:   if (cfg_en) begin
                         m_ratio = cfg_ratio; m_pen = cfg_parity_en; m_podd = cfg_parity_odd;
                         m_st = M_IDLE;
                     end
            M_IDLE:  if (rx_busy) m_st = M_RECV; else if (!cfg_en) m_st = M_OFF;
            M_RECV:  if (rx_new_data || !rx_busy) m_st = M_IDLE; else if (!cfg_en) m_st = M_DRAIN;
            default: if (!rx_busy && !rx_new_data) m_st = M_OFF;
        endcase
    endtask

    task automatic compare_all();
        logic exp_enb;
        exp_enb = (m_st == M_RECV) || (m_st == M_IDLE && !(cfg_flow && q.size() == DEPTH));
        check("rx_enb", rx_enb, exp_enb);
        check("ratio", ratio, m_ratio);
        check("parity_en", parity_en, m_pen);
        check("parity_odd", parity_odd, m_podd);
        check("rd_valid", rd_valid, q.size() > 0);
        check("fifo_count", fifo_count, q.size());
        if (q.size() > 0) begin
            check("rd_data", rd_data, q[0][7:0]);
            check("rd_perr", rd_perr, q[0][8]);
        end
        check("overflow", overflow, m_ovf);
        check("timeout_irq", timeout_irq, m_irq);
        check("perr_count", perr_count, m_perr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe);
        rx_busy = 1; tick();
        rx_new_data = 1; rx_data = d; rx_parity_err = pe; tick();
        rx_busy = 0; rx_new_data = 0; rx_parity_err = 0; tick();
    endtask

    task automatic pop();
        rd_en = 1; tick();
        rd_en = 0;
    endtask

    initial begin
        model_reset();
        tick(); tick();
        reset_n = 0;
        tick();
        check("rst_enb", rx_enb, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ratio", ratio, 0);

        // three bytes in order, show-ahead head
        cfg_en = 1; cfg_ratio = 8'd16; cfg_parity_en = 1; cfg_parity_odd = 0;
        tick();
        check("ratio_latched", ratio, 16);
        send_byte(8'h55, 0);
        send_byte(8'hA3, 1);
        send_byte(8'h0F, 0);
        check("three_count", fifo_count, 3);
        check("three_head", rd_data, 8'h55);
        pop();
        check("second", rd_data, 8'hA3);
        pop();
        check("third", rd_data, 8'h0F);
        pop();
        check("empty_after3", rd_valid, 0);

        // cfg changes while enabled do not reach the shadows
        cfg_ratio = 8'd99; cfg_parity_odd = 1;
        tick(); tick();
        check("ratio_held", ratio, 16);
        check("podd_held", parity_odd, 0);

        // overflow with flow control off
        cfg_flow = 0;
        for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i), 0);
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_order", rd_data, 8'(8'h10 + i));
            pop();
        end
        check("ninth_absent", rd_valid, 0);
        stat_clr = 1; tick(); stat_clr = 0;
        check("ovf_clr", overflow, 0);

        // flow control holds off while full
        cfg_flow = 1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i), 0);
        check("flow_full", fifo_count, 8);
        check("flow_enb", rx_enb, 0);

        // simultaneous read and write on a full FIFO
        rd_en = 1; rx_busy = 1; rx_new_data = 1; rx_data = 8'hEE; tick();
        rd_en = 0; rx_busy = 0; rx_new_data = 0; tick();
        check("rw_count", fifo_count, 8);
        check("rw_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) pop();
        check("rw_last", rd_data, 8'hEE);
        pop();
        cfg_flow = 0;

        // idle timeout exactly 100 clocks after the write
        cfg_timeout = 16'd100;
        rx_busy = 1; tick();
        rx_new_data = 1; rx_data = 8'h77; tick();
        rx_busy = 0; rx_new_data = 0;
        for (int i = 1; i < 100; i++) tick();
        check("to_before", timeout_irq, 0);
        tick();
        check("to_at", timeout_irq, 1);
        stat_clr = 1; tick(); stat_clr = 0;
        check("to_clr", timeout_irq, 0);
        pop();
        cfg_timeout = 16'd0;

        // disable mid-frame drains the in-flight byte
        rx_busy = 1; tick();
        cfg_en = 0; tick();
        check("drain_enb", rx_enb, 0);
        rx_new_data = 1; rx_data = 8'h3C; tick();
        rx_busy = 0; rx_new_data = 0; tick();
        tick();
        check("drain_count", fifo_count, 1);
        check("drain_data", rd_data, 8'h3C);
        check("off_enb", rx_enb, 0);

        // asynchronous reset mid-frame
        cfg_en = 1; tick();
        send_byte(8'h81, 1);
        rx_busy = 1; tick();
        #2 reset_n = 1;
        #1;
        model_reset();
        check("ar_enb", rx_enb, 0);
        check("ar_ratio", ratio, 0);
        check("ar_pen", parity_en, 0);
        check("ar_podd", parity_odd, 0);
        check("ar_data", rd_data, 0);
        check("ar_perr", rd_perr, 0);
        check("ar_valid", rd_valid, 0);
        check("ar_count", fifo_count, 0);
        check("ar_ovf", overflow, 0);
        check("ar_irq", timeout_irq, 0);
        check("ar_perrcnt", perr_count, 0);
        #1 reset_n = 0;
        rx_busy = 0; cfg_en = 0;
        tick();
        check("post_rst_off", rx_enb, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                cfg_flow    = 1'($urandom_range(0, 1));
                cfg_timeout = 16'($urandom_range(1, 12));
            end
            cfg_en         = ($urandom_range(0, 19) != 0);
            cfg_ratio      = 8'($urandom);
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            rx_busy        = ($urandom_range(0, 3) != 0);
            rx_new_data    = ($urandom_range(0, 2) == 0);
            rx_parity_err  = 1'($urandom);
            rx_data        = 8'($urandom);
            rd_en          = ($urandom_range(0, 3) == 0);
            stat_clr       = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter RATIO_REG_SIZE, default 8: width of the baud ratio.
REQ-002 SHALL have parameter DATA_BITS, default 8: width of a data byte.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2): number of receive FIFO entries.
REQ-004 SHALL have parameter TO_BITS, default 16: width of the idle-timeout counter.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous, active-high.
- cfg_en  in  1  enable reception.
- cfg_ratio  in  RATIO_REG_SIZE  clocks per bit.
- cfg_parity_en  in  1  parity enable.
- cfg_parity_odd  in  1  parity select.
- cfg_flow  in  1  1 = hold off reception while FIFO full.
- cfg_timeout  in  TO_BITS  idle timeout in clocks; 0 disables.
- rx_busy, rx_new_data, rx_parity_err  in  1 each  status from the receiver.
- rx_data  in  DATA_BITS  received byte from the receiver.
- rx_enb  out  1  receiver start permission.
- ratio  out  RATIO_REG_SIZE  shadowed ratio to the receiver.
- parity_en, parity_odd  out  1 each  shadowed parity settings to the receiver.
- rd_en  in  1  pop the FIFO head.
- rd_data  out  DATA_BITS  FIFO head byte.
- rd_perr  out  1  parity-error flag of the head entry.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: a byte was dropped.
- timeout_irq  out  1  sticky: idle timeout expired.
- perr_count  out  8  saturating count of parity errors.
- stat_clr  in  1  clears overflow, timeout_irq and perr_count.

Function
REQ-006 SHALL implement states OFF, IDLE, RECV and DRAIN.
REQ-007 OFF: on cfg_en=1, SHALL latch cfg_ratio, cfg_parity_en and cfg_parity_odd into the ratio/parity_en/parity_odd registers and go to IDLE the next cycle.
REQ-008 Shadow registers SHALL change only on the OFF->IDLE transition; cfg changes while enabled are ignored.
REQ-009 IDLE: rx_busy=1 SHALL go to RECV; cfg_en=0 with rx_busy=0 SHALL go to OFF.
REQ-010 RECV: rx_new_data=1 SHALL go to IDLE; rx_busy=0 without rx_new_data (framing abort) SHALL go to IDLE with no write.
REQ-011 cfg_en=0 during RECV SHALL go to DRAIN; DRAIN SHALL accept the in-flight byte and go to OFF when rx_busy=0 and rx_new_data=0.
REQ-012 rx_enb SHALL be 1 only in IDLE and RECV, and SHALL be 0 in IDLE when cfg_flow=1 and the FIFO is full.
REQ-013 An rx_new_data pulse SHALL write {rx_parity_err, rx_data} to the FIFO in the same cycle; latency to rd_valid is 1 clock.
REQ-014 FIFO SHALL be show-ahead: rd_data/rd_perr present the head whenever rd_valid=1.
REQ-015 rd_en while empty SHALL be ignored.
REQ-016 A write while full SHALL drop the byte and set overflow, unless rd_en is 1 in the same cycle, in which case both the read and the write occur and fifo_count is unchanged.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 fifo_count SHALL equal writes minus reads.
REQ-019 Simultaneous read and write on an empty FIFO SHALL perform the write only.
REQ-020 perr_count SHALL increment on each accepted write with rx_parity_err=1 and saturate at 255.
REQ-021 Timeout counter SHALL clear on any write, read or stat_clr.
REQ-022 Timeout counter SHALL increment while rx_busy=0 and rd_valid=1.
REQ-023 When the timeout counter reaches cfg_timeout (nonzero), timeout_irq SHALL set and the counter SHALL hold.
REQ-024 stat_clr SHALL take priority over any set of overflow/timeout_irq/perr_count in the same cycle.
REQ-025 FIFO contents SHALL be preserved across OFF; only reset flushes them.

Reset
REQ-026 reset_n=1 SHALL asynchronously force state OFF, FIFO empty, and all outputs to 0 (rx_enb, ratio, parity_en, parity_odd, rd_data, rd_perr, rd_valid, fifo_count, overflow, timeout_irq, perr_count).
REQ-027 Reset mid-frame SHALL discard the frame; after release, reception restarts only via cfg_en.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding localparams and the default FIFO_DEPTH/TO_BITS constants.
REQ-029 The FIFO SHALL be a separate sub-module, uart_rx_fifo (synchronous, show-ahead, full/empty/count outputs).

Verification
REQ-030 Bench SHALL cover: cfg_en=1, cfg_ratio=16, three bytes 0x55/0xA3/0x0F via rx_new_data pulses -> fifo_count=3, rd_data=0x55, then 0xA3 and 0x0F on successive rd_en.
REQ-031 Bench SHALL cover: cfg_flow=0, 9 writes with no reads -> fifo_count=8, overflow=1, 9th byte absent; cfg_flow=1 -> rx_enb=0 while full.
REQ-032 Bench SHALL cover: full FIFO with rd_en and rx_new_data in the same cycle -> count stays 8, new byte is last out.
REQ-033 Bench SHALL cover: cfg_timeout=100, one byte written, no reads -> timeout_irq=1 exactly 100 clocks after the write; stat_clr -> 0.
REQ-034 Bench SHALL cover: cfg_en=0 during RECV -> DRAIN, byte stored, then OFF with rx_enb=0; cfg_ratio changed while enabled -> ratio output unchanged.
REQ-035 Bench SHALL cover: reset_n pulse mid-frame -> all outputs 0 immediately, FIFO empty.
